// File: rtl/day10_pkg.sv
// Shared constants for the day-10 machine-record parser and the downstream solver:
// record sizing, the ASCII tokens of the puzzle grammar and the parser state encoding.
package day10_pkg;
  localparam int MAX_BUTTONS = 13;
  localparam int DATA_WIDTH  = 32;

  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_RBRACK = 8'h5D;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;

  typedef enum logic [2:0] {
    LINE_START = 3'd0,
    LIGHT      = 3'd1,
    SEP        = 3'd2,
    BUTTON     = 3'd3,
    JOLT       = 3'd4,
    EMIT       = 3'd5,
    FINISHED   = 3'd6
  } state_t;
endpackage

// File: rtl/day10_parser.sv
// Streams puzzle text one byte per cycle and emits one record per machine line
// (light mask plus button masks); the record registers also serve as the output hold.
//
// state      | meaning
// LINE_START | between lines; '[' opens a record
// LIGHT      | collecting '#'/'.' light characters
// SEP        | between groups; '(' opens a button, '{' opens joltages
// BUTTON     | accumulating decimal indices of one button group
// JOLT       | discarding joltages until LF (or in_last)
// EMIT       | record presented, input stalled until out_ready
// FINISHED   | end of input, all records taken; input refused
module day10_parser
  import day10_pkg::*;
#(
  parameter int MAX_BUTTONS = day10_pkg::MAX_BUTTONS,
  parameter int DATA_WIDTH  = day10_pkg::DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_light,
  output logic [5:0]                        out_num_lights,
  output logic [4:0]                        out_num_buttons,
  output logic [MAX_BUTTONS*DATA_WIDTH-1:0] out_buttons,
  output logic [15:0]                       machine_count,
  output logic                              done,
  output logic                              err
);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] light;
  logic [5:0]            num_lights;
  logic [4:0]            num_buttons;
  logic [DATA_WIDTH-1:0] buttons [MAX_BUTTONS];
  logic [DATA_WIDTH-1:0] scratch;
  logic [7:0]            acc;
  logic                  eof;

  logic                  take;
  logic                  is_digit;
  logic                  err_set;
  logic [11:0]           acc_prod;
  logic [7:0]            acc_next;
  logic                  light_ovf;
  logic                  acc_ovf;
  logic                  slots_full;

  // Out-of-range indices produce an all-zero mask, which is how dropped bits vanish.
  function automatic logic [DATA_WIDTH-1:0] onehot(input logic [7:0] idx);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = (int'(idx) == i);
    return m;
  endfunction

  assign take       = in_valid && in_ready;
  assign is_digit   = (in_data >= CH_ZERO) && (in_data <= CH_NINE);
  assign acc_prod   = {4'd0, acc} * 12'd10 + {8'd0, in_data[3:0]};
  assign acc_next   = (acc_prod > 12'd255) ? 8'd255 : acc_prod[7:0];
  assign light_ovf  = int'(num_lights) >= DATA_WIDTH;
  assign acc_ovf    = int'(acc) >= DATA_WIDTH;
  assign slots_full = int'(num_buttons) >= MAX_BUTTONS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LINE_START;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    unique case (state)
      LINE_START: if (take) begin
        if (in_data == CH_LBRACK) state_next = LIGHT;
        else if (in_data != CH_SPACE && in_data != CH_CR && in_data != CH_LF) err_set = 1'b1;
        if (in_last) state_next = FINISHED;
      end
      LIGHT: if (take) begin
        if (in_data == CH_RBRACK) state_next = SEP;
        else if (in_data == CH_HASH || in_data == CH_DOT) err_set = light_ovf;
        else err_set = 1'b1;
        if (in_last) begin
          err_set    = 1'b1;
          state_next = FINISHED;
        end
      end
      SEP: if (take) begin
        if (in_data == CH_LPAREN) state_next = BUTTON;
        else if (in_data == CH_LBRACE) state_next = JOLT;
        else if (in_data != CH_SPACE) err_set = 1'b1;
        if (in_last) begin
          err_set    = 1'b1;
          state_next = FINISHED;
        end
      end
      BUTTON: if (take) begin
        if (in_data == CH_COMMA) err_set = acc_ovf;
        else if (in_data == CH_RPAREN) begin
          err_set    = acc_ovf || slots_full;
          state_next = SEP;
        end else if (!is_digit) err_set = 1'b1;
        if (in_last) begin
          err_set    = 1'b1;
          state_next = FINISHED;
        end
      end
      JOLT: if (take && (in_data == CH_LF || in_last)) state_next = EMIT;
      EMIT: if (out_ready) state_next = eof ? FINISHED : LINE_START;
      FINISHED: state_next = FINISHED;
      default: state_next = LINE_START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light         <= '0;
      num_lights    <= '0;
      num_buttons   <= '0;
      scratch       <= '0;
      acc           <= '0;
      eof           <= 1'b0;
      err           <= 1'b0;
      machine_count <= '0;
      for (int k = 0; k < MAX_BUTTONS; k++) buttons[k] <= '0;
    end else begin
      if (err_set) err <= 1'b1;
      if (take && in_last) eof <= 1'b1;
      if (state == EMIT && out_ready) machine_count <= machine_count + 16'd1;
      if (take) begin
        unique case (state)
          LINE_START: if (in_data == CH_LBRACK) begin
            light       <= '0;
            num_lights  <= '0;
            num_buttons <= '0;
            scratch     <= '0;
            acc         <= '0;
            for (int k = 0; k < MAX_BUTTONS; k++) buttons[k] <= '0;
          end
          LIGHT: if (in_data == CH_HASH || in_data == CH_DOT) begin
            if (in_data == CH_HASH) light <= light | onehot({2'b00, num_lights});
            if (num_lights != 6'd63) num_lights <= num_lights + 6'd1;
          end
          SEP: if (in_data == CH_LPAREN) begin
            acc     <= '0;
            scratch <= '0;
          end
          BUTTON: begin
            if (is_digit) acc <= acc_next;
            else if (in_data == CH_COMMA) begin
              scratch <= scratch | onehot(acc);
              acc     <= '0;
            end else if (in_data == CH_RPAREN) begin
              acc <= '0;
              if (!slots_full) begin
                for (int k = 0; k < MAX_BUTTONS; k++)
                  if (int'(num_buttons) == k) buttons[k] <= scratch | onehot(acc);
                num_buttons <= num_buttons + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready        = (state != EMIT) && (state != FINISHED);
  assign out_valid       = (state == EMIT);
  assign done            = (state == FINISHED);
  assign out_light       = light;
  assign out_num_lights  = num_lights;
  assign out_num_buttons = num_buttons;

  for (genvar g = 0; g < MAX_BUTTONS; g++) begin : g_btn
    assign out_buttons[g*DATA_WIDTH +: DATA_WIDTH] = buttons[g];
  end

endmodule

// File: tb/tb_day10_parser.sv
// Scoreboard bench for day10_parser: stimulus pushes hand-computed records,
// a monitor pops and compares them on every output handshake.
module tb_day10_parser;
  import day10_pkg::*;

  localparam int NB = 13;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0]    light;
    logic [5:0]       nl;
    logic [4:0]       nb;
    logic [NB*DW-1:0] btn;
    logic             err;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_light;
  logic [5:0]        out_num_lights;
  logic [4:0]        out_num_buttons;
  logic [NB*DW-1:0]  out_buttons;
  logic [15:0]       machine_count;
  logic              done;
  logic              err;

  int                vectors = 0;
  int                miscompares = 0;
  rec_t              exp_q[$];
  logic [DW-1:0]     exp_btn [NB];

  day10_parser #(.MAX_BUTTONS(NB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_light(out_light), .out_num_lights(out_num_lights),
    .out_num_buttons(out_num_buttons), .out_buttons(out_buttons),
    .machine_count(machine_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NB*DW-1:0] act, input logic [NB*DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_btn();
    for (int k = 0; k < NB; k++) exp_btn[k] = '0;
  endtask

  task automatic push_exp(input logic [DW-1:0] light, input logic [5:0] nl,
                          input logic [4:0] nb, input logic e);
    rec_t r;
    r.light = light;
    r.nl    = nl;
    r.nb    = nb;
    r.err   = e;
    for (int k = 0; k < NB; k++) r.btn[k*DW +: DW] = exp_btn[k];
    exp_q.push_back(r);
  endtask

  // Monitor: a record counts when valid and ready are both seen mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("light", out_light, r.light);
        chk("num_lights", out_num_lights, r.nl);
        chk("num_buttons", out_num_buttons, r.nb);
        chk("buttons", out_buttons, r.btn);
        chk("err_at_emit", err, r.err);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_at_end);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last_at_end && (i == s.len() - 1));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_machine_count", machine_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_light", out_light, 0);
    chk("rst_out_buttons", out_buttons, 0);

    // Example line, with downstream backpressure held for 5 cycles.
    clear_btn();
    exp_btn[0] = 32'h8; exp_btn[1] = 32'hA; exp_btn[2] = 32'h4;
    exp_btn[3] = 32'hC; exp_btn[4] = 32'h5; exp_btn[5] = 32'h3;
    push_exp(32'h6, 6'd4, 5'd6, 1'b0);
    out_ready = 1'b0;
    send_str("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_light", out_light, 32'h6);
      chk("hold_num_buttons", out_num_buttons, 5'd6);
      chk("hold_button3", out_buttons[3*DW +: DW], 32'hC);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_example");
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    chk("count_example", machine_count, 1);

    // Multi-digit indices, then an index beyond the mask width.
    clear_btn();
    exp_btn[0] = 32'h1400;
    push_exp(32'h1, 6'd1, 5'd1, 1'b0);
    clear_btn();
    exp_btn[1] = 32'h2;
    push_exp(32'h2, 6'd2, 5'd2, 1'b1);
    send_str("[#] (10,12) {1}\n", 1'b0);
    send_str("[.#] (40) (1) {2}\n", 1'b0);
    wait_drain("drain_index");
    chk("err_sticky", err, 1);
    chk("count_index", machine_count, 3);

    // Fourteen button groups: the last is discarded.
    do_reset();
    clear_btn();
    for (int k = 0; k < NB; k++) exp_btn[k] = 32'h1 << k;
    push_exp(32'h1, 6'd2, 5'd13, 1'b1);
    send_str("[#.] (0) (1) (2) (3) (4) (5) (6) (7) (8) (9) (10) (11) (12) (13) {0}\n", 1'b0);
    wait_drain("drain_overflow");

    // Reset in the middle of a button group abandons that line.
    do_reset();
    send_str("[##] (1,2", 1'b0);
    do_reset();
    clear_btn();
    exp_btn[0] = 32'h5; exp_btn[1] = 32'h2;
    push_exp(32'h2, 6'd3, 5'd2, 1'b0);
    send_str("[.#.] (0,2) (1) {5}\n", 1'b0);
    wait_drain("drain_midreset");
    chk("count_midreset", machine_count, 1);
    chk("err_midreset", err, 0);

    // Three lines, the last terminated by in_last on '}'.
    do_reset();
    clear_btn();
    exp_btn[0] = 32'h3;
    push_exp(32'h3, 6'd2, 5'd1, 1'b0);
    clear_btn();
    exp_btn[0] = 32'h8; exp_btn[1] = 32'h1;
    push_exp(32'h9, 6'd4, 5'd2, 1'b0);
    clear_btn();
    exp_btn[0] = 32'h1;
    push_exp(32'h1, 6'd1, 5'd1, 1'b0);
    send_str("[##] (0,1) {3}\n", 1'b0);
    send_str("[#..#] (3) (0) {1,2}\n", 1'b0);
    send_str("[#] (0) {1}", 1'b1);
    wait_drain("drain_eof");
    @(negedge clk);
    chk("eof_done", done, 1);
    chk("eof_count", machine_count, 3);
    chk("eof_in_ready", in_ready, 0);
    chk("eof_err", err, 0);
    chk("eof_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/day10_parser.md
DAY10_PARSER -- requirements
Module: day10_parser

Interface
REQ-001 SHALL have parameter MAX_BUTTONS, default 13, maximum button groups stored per machine.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the light mask and of each button mask.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  8  ASCII byte of puzzle text.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_last  input  1  marks the final byte of the input.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port out_valid  output  1  machine record is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the record.
REQ-011 SHALL have port out_light  output  DATA_WIDTH  target mask; bit i is light i.
REQ-012 SHALL have port out_num_lights  output  6  number of light characters parsed.
REQ-013 SHALL have port out_num_buttons  output  5  number of stored button groups.
REQ-014 SHALL have port out_buttons  output  MAX_BUTTONS*DATA_WIDTH  button k mask in bits [k*DATA_WIDTH +: DATA_WIDTH]; unused slots are zero.
REQ-015 SHALL have port machine_count  output  16  records accepted downstream.
REQ-016 SHALL have port done  output  1  sticky; end of input reached and all records accepted.
REQ-017 SHALL have port err  output  1  sticky; a format or overflow error has occurred.

Function
REQ-018 SHALL implement FSM states LINE_START, LIGHT, SEP, BUTTON, JOLT, EMIT, FINISHED.
REQ-019 SHALL drive in_ready high in every state except EMIT and FINISHED.
REQ-020 In LINE_START: '[' clears light, counters and all button masks, then goes to LIGHT; space, CR and LF are ignored; any other byte sets err.
REQ-021 In LIGHT: '#' sets light bit num_lights; '.' leaves it clear; either increments num_lights; ']' goes to SEP.
REQ-022 In SEP: '(' clears the index accumulator and scratch mask, then goes to BUTTON; '{' goes to JOLT; space is ignored.
REQ-023 In BUTTON: a digit updates acc = acc*10 + d; ',' ORs bit acc into the scratch mask and clears acc; ')' ORs bit acc in, stores the scratch mask at slot num_buttons, increments num_buttons and goes to SEP.
REQ-024 In JOLT: all bytes are discarded until LF, which goes to EMIT.
REQ-025 In EMIT: out_valid is high and all out_* fields are held stable until out_ready; on the handshake cycle out_valid drops, machine_count increments, and the next state is FINISHED if EOF is latched, otherwise LINE_START.
REQ-026 out_valid SHALL rise on the cycle after the terminating LF is accepted, so the first emit cycle is one cycle after the LF.
REQ-027 When in_last is accepted, EOF SHALL be latched; in JOLT, in_last also acts as LF; in LINE_START, the next state is FINISHED.
REQ-028 If in_last is accepted in LIGHT, SEP or BUTTON, err SHALL be set, no record is emitted and the next state is FINISHED.
REQ-029 In FINISHED, done SHALL be high and every input byte is refused.
REQ-030 A button index >= DATA_WIDTH or a light index >= DATA_WIDTH SHALL set err and drop that bit.
REQ-031 The (MAX_BUTTONS+1)th button group SHALL set err and be discarded; num_buttons saturates at MAX_BUTTONS.
REQ-032 The index accumulator SHALL be 8 bits and saturate at 255.
REQ-033 Throughput SHALL be one byte per cycle, with no stall outside EMIT.

Reset
REQ-034 On rst: state LINE_START; out_valid, done, err = 0; machine_count = 0; out_light, out_num_lights, out_num_buttons, out_buttons = 0; EOF flag clear.
REQ-035 rst asserted mid-line or during EMIT SHALL abandon the partial or pending record with no output handshake.

Structure
REQ-036 Package day10_pkg SHALL hold MAX_BUTTONS, DATA_WIDTH, the ASCII constants ('[', ']', '(', ')', '{', ',', '#', '.', LF) and the FSM state encoding, shared with the downstream solver.
REQ-037 The block SHALL be a single module with no sub-module; the record registers double as the output holding register.

Verification
REQ-038 Input "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" SHALL produce light=0x6, num_lights=4, num_buttons=6, buttons=0x8,0xA,0x4,0xC,0x5,0x3, with machine_count=1.
REQ-039 Holding out_ready low for 5 cycles SHALL keep out_valid=1, in_ready=0 and all fields stable; out_ready=1 then completes the record and in_ready returns to 1 on the next cycle.
REQ-040 Button "(10,12)" SHALL yield mask 0x1400; "(40)" SHALL set err=1 and leave that mask at 0x0.
REQ-041 A line with 14 button groups SHALL set err=1 and emit num_buttons=13, with groups 0..12 intact.
REQ-042 Three lines where the last ends with '}' carrying in_last and no LF SHALL emit three records, then give done=1, machine_count=3 and in_ready=0.
REQ-043 Pulsing rst during BUTTON and then sending a full line SHALL emit only the new line's record, with machine_count=1 and err=0.
